// File: rtl/wave_pkg.sv
// Shared types for the waveform step sequencer.
// Step slot layout, waveform codes and FSM states.
package wave_pkg;

    localparam int PKG_FW = 16;
    localparam int PKG_DW = 8;

    typedef enum logic [1:0] {
        WAVE_SINE,
        WAVE_SQUARE,
        WAVE_TRI,
        WAVE_SAW
    } wave_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } seq_state_t;

    typedef struct packed {
        wave_t              wave;
        logic [PKG_FW-1:0]  inc;
        logic [PKG_DW-1:0]  dur;
    } step_t;

endpackage

// File: rtl/wave_step_mem.sv
// Step slot register file: one write port, one combinational read port.
// Contents are intentionally not reset.
module wave_step_mem
    import wave_pkg::*;
#(
    parameter int STEPS = 8,
    localparam int AW = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  step_t         wdata,
    input  logic [AW-1:0] raddr,
    output step_t         rdata
);

    step_t mem [STEPS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wave_step_sequencer.sv
// Plays programmed waveform steps onto the NCO tuning word and wave select.
// Optional WAVE_SEQ_LOOP_EN: wrap to step 0 forever instead of finishing.
module wave_step_sequencer
    import wave_pkg::*;
#(
    parameter int STEPS = 8,
    parameter int FW = PKG_FW,
    parameter int DW = PKG_DW,
    localparam int AW = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [1:0]    cfg_wave,
    input  logic [FW-1:0] cfg_inc,
    input  logic [DW-1:0] cfg_dur,
    input  logic [AW:0]   nsteps,
    input  logic          start,
    input  logic          stop,
    input  logic          tick,
    output logic [1:0]    wave_sel,
    output logic [FW-1:0] phase_inc,
    output logic          out_en,
    output logic [AW-1:0] step_idx,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    localparam int CW = DW + 1;
    localparam logic [AW:0] N_MAX = (AW+1)'(STEPS);
    localparam logic [AW:0] N_ONE = (AW+1)'(1);

    seq_state_t    state;
    logic [AW:0]   n_lat;
    logic [AW-1:0] idx;
    logic [CW-1:0] dur_cnt;
    step_t         wr;
    step_t         rd;
    logic          last;
    logic          n_ok;

    assign wr = '{wave: wave_t'(cfg_wave), inc: cfg_inc, dur: cfg_dur};

    wave_step_mem #(.STEPS(STEPS)) u_mem (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (wr),
        .raddr (idx),
        .rdata (rd)
    );

    assign last     = ({1'b0, idx} == (n_lat - N_ONE));
    assign n_ok     = (nsteps != '0) && (nsteps <= N_MAX);
    assign step_idx = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            n_lat     <= '0;
            idx       <= '0;
            dur_cnt   <= '0;
            wave_sel  <= '0;
            phase_inc <= '0;
            out_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        if (n_ok) begin
                            n_lat <= nsteps;
                            idx   <= '0;
                            busy  <= 1'b1;
                            state <= S_LOAD;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (stop) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        out_en    <= 1'b0;
                        phase_inc <= '0;
                    end else begin
                        wave_sel  <= rd.wave;
                        phase_inc <= rd.inc;
                        dur_cnt   <= (rd.dur == '0) ? {1'b1, {DW{1'b0}}}
                                                    : {1'b0, rd.dur};
                        out_en    <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        out_en    <= 1'b0;
                        phase_inc <= '0;
                    end else if (tick) begin
                        if (dur_cnt == CW'(1)) begin
                            if (!last) begin
                                idx   <= idx + AW'(1);
                                state <= S_LOAD;
                            end else begin
`ifdef WAVE_SEQ_LOOP_EN
                                idx   <= '0;
                                done  <= 1'b1;
                                state <= S_LOAD;
`else
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                out_en    <= 1'b0;
                                phase_inc <= '0;
                                state     <= S_DONE;
`endif
                            end
                        end else begin
                            dur_cnt <= dur_cnt - CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_step_sequencer.sv
// Directed testbench for wave_step_sequencer.
// Loop-mode scenario is compiled in when WAVE_SEQ_LOOP_EN is defined.
module tb_wave_step_sequencer;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [1:0]  cfg_wave;
    logic [15:0] cfg_inc;
    logic [7:0]  cfg_dur;
    logic [3:0]  nsteps;
    logic        start;
    logic        stop;
    logic        tick;
    logic [1:0]  wave_sel;
    logic [15:0] phase_inc;
    logic        out_en;
    logic [2:0]  step_idx;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    wave_step_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wave  (cfg_wave),
        .cfg_inc   (cfg_inc),
        .cfg_dur   (cfg_dur),
        .nsteps    (nsteps),
        .start     (start),
        .stop      (stop),
        .tick      (tick),
        .wave_sel  (wave_sel),
        .phase_inc (phase_inc),
        .out_en    (out_en),
        .step_idx  (step_idx),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic write_slot(input logic [2:0] a, input logic [1:0] w,
                              input logic [15:0] inc, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_wave = w;
        cfg_inc  = inc;
        cfg_dur  = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic start_seq(input logic [3:0] n);
        nsteps = n;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++;
        if ({wave_sel, phase_inc, out_en, step_idx, busy, done, cfg_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h %h %b %h %b %b %b exp all zero",
                     wave_sel, phase_inc, out_en, step_idx, busy, done, cfg_err);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        write_slot(3'd0, 2'd1, 16'h0100, 8'd3);
        write_slot(3'd1, 2'd3, 16'h0400, 8'd2);
        start_seq(4'd2);
        checks++;
        if (busy !== 1'b1 || out_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_load got busy=%b out_en=%b exp 1 0", busy, out_en);
        end
        idle(1);
        checks++;
        if (phase_inc !== 16'h0100 || wave_sel !== 2'd1 || out_en !== 1'b1 || step_idx !== 3'd0) begin
            errors++;
            $display("FAIL basic_step0 got inc=%h wave=%0d en=%b idx=%0d exp 0100 1 1 0",
                     phase_inc, wave_sel, out_en, step_idx);
        end
        pulse_tick();
        idle(3);
        pulse_tick();
        idle(3);
        checks++;
        if (phase_inc !== 16'h0100) begin
            errors++;
            $display("FAIL basic_hold0 got %h exp 0100", phase_inc);
        end
        pulse_tick();
        checks++;
        if (step_idx !== 3'd1 || phase_inc !== 16'h0100 || out_en !== 1'b1) begin
            errors++;
            $display("FAIL basic_load_hold got idx=%0d inc=%h en=%b exp 1 0100 1",
                     step_idx, phase_inc, out_en);
        end
        idle(1);
        checks++;
        if (phase_inc !== 16'h0400 || wave_sel !== 2'd3) begin
            errors++;
            $display("FAIL basic_step1 got inc=%h wave=%0d exp 0400 3", phase_inc, wave_sel);
        end
        idle(2);
        pulse_tick();
        idle(3);
        checks++;
        if (phase_inc !== 16'h0400 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold1 got inc=%h done=%b exp 0400 0", phase_inc, done);
        end
        pulse_tick();
        checks++;
        if (done !== 1'b1 || out_en !== 1'b0 || phase_inc !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got done=%b en=%b inc=%h busy=%b exp 1 0 0000 0",
                     done, out_en, phase_inc, busy);
        end
        idle(1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got %b exp 0", done);
        end
    endtask

    task automatic test_cfg_err();
        start_seq(4'd0);
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || phase_inc !== 16'h0000 || out_en !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_zero got err=%b busy=%b inc=%h en=%b exp 1 0 0000 0",
                     cfg_err, busy, phase_inc, out_en);
        end
        idle(1);
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse got err=%b busy=%b exp 0 0", cfg_err, busy);
        end
        start_seq(4'd9);
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_nine got err=%b busy=%b exp 1 0", cfg_err, busy);
        end
        idle(1);
    endtask

    task automatic test_dur_zero();
        int cnt;
        write_slot(3'd0, 2'd0, 16'h0010, 8'd0);
        start_seq(4'd1);
        idle(1);
        tick = 1'b1;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (done) break;
        end
        tick = 1'b0;
        checks++;
        if (cnt !== 256) begin
            errors++;
            $display("FAIL dur_zero_ticks got %0d exp 256", cnt);
        end
        idle(1);
    endtask

    task automatic test_stop();
        logic saw_done;
        write_slot(3'd0, 2'd1, 16'h0100, 8'd3);
        write_slot(3'd1, 2'd3, 16'h0400, 8'd4);
        start_seq(4'd2);
        idle(1);
        repeat (3) begin
            pulse_tick();
            idle(1);
        end
        pulse_tick();
        idle(1);
        pulse_tick();
        idle(1);
        checks++;
        if (step_idx !== 3'd1 || phase_inc !== 16'h0400 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_pre got idx=%0d inc=%h busy=%b exp 1 0400 1",
                     step_idx, phase_inc, busy);
        end
        stop  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        stop  = 1'b0;
        start = 1'b0;
        saw_done = done;
        checks++;
        if (busy !== 1'b0 || out_en !== 1'b0 || phase_inc !== 16'h0000 || done !== 1'b0) begin
            errors++;
            $display("FAIL stop_abort got busy=%b en=%b inc=%h done=%b exp 0 0 0000 0",
                     busy, out_en, phase_inc, done);
        end
        idle(1);
        saw_done = saw_done | done;
        checks++;
        if (busy !== 1'b0 || saw_done !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle got busy=%b done=%b exp 0 0", busy, saw_done);
        end
        nsteps = 4'd2;
        stop   = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        stop  = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_wins_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_write_during_run();
        write_slot(3'd0, 2'd2, 16'h0100, 8'd3);
        start_seq(4'd1);
        idle(1);
        write_slot(3'd0, 2'd2, 16'h0FFF, 8'd3);
        pulse_tick();
        checks++;
        if (phase_inc !== 16'h0100) begin
            errors++;
            $display("FAIL wr_run_hold got %h exp 0100", phase_inc);
        end
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        start_seq(4'd1);
        idle(1);
        checks++;
        if (phase_inc !== 16'h0FFF || wave_sel !== 2'd2) begin
            errors++;
            $display("FAIL wr_run_next got inc=%h wave=%0d exp 0fff 2", phase_inc, wave_sel);
        end
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic test_reset_mid();
        write_slot(3'd0, 2'd1, 16'h0123, 8'd5);
        start_seq(4'd1);
        idle(1);
        checks++;
        if (out_en !== 1'b1 || phase_inc !== 16'h0123) begin
            errors++;
            $display("FAIL rst_mid_pre got en=%b inc=%h exp 1 0123", out_en, phase_inc);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_en !== 1'b0 || busy !== 1'b0 || phase_inc !== 16'h0000 || wave_sel !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_async got en=%b busy=%b inc=%h wave=%0d exp 0 0 0000 0",
                     out_en, busy, phase_inc, wave_sel);
        end
        idle(1);
        rst = 1'b0;
        idle(1);
    endtask

`ifdef WAVE_SEQ_LOOP_EN
    task automatic test_loop();
        write_slot(3'd0, 2'd1, 16'h0100, 8'd1);
        write_slot(3'd1, 2'd3, 16'h0400, 8'd1);
        start_seq(4'd2);
        idle(1);
        pulse_tick();
        checks++;
        if (step_idx !== 3'd1 || done !== 1'b0 || out_en !== 1'b1) begin
            errors++;
            $display("FAIL loop_step1 got idx=%0d done=%b en=%b exp 1 0 1", step_idx, done, out_en);
        end
        idle(1);
        pulse_tick();
        checks++;
        if (step_idx !== 3'd0 || done !== 1'b1 || out_en !== 1'b1) begin
            errors++;
            $display("FAIL loop_wrap got idx=%0d done=%b en=%b exp 0 1 1", step_idx, done, out_en);
        end
        idle(1);
        checks++;
        if (done !== 1'b0 || phase_inc !== 16'h0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL loop_again got done=%b inc=%h busy=%b exp 0 0100 1", done, phase_inc, busy);
        end
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        checks++;
        if (out_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop got en=%b busy=%b exp 0 0", out_en, busy);
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_wave = '0;
        cfg_inc  = '0;
        cfg_dur  = '0;
        nsteps   = '0;
        start    = 1'b0;
        stop     = 1'b0;
        tick     = 1'b0;
        test_reset();
`ifdef WAVE_SEQ_LOOP_EN
        test_loop();
`else
        test_basic();
        test_dur_zero();
`endif
        test_cfg_err();
        test_stop();
        test_write_during_run();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
